axi_dma_receive_transfer_initiator: RTL and testbench

//  AXI-Lite master that programs the AXI DMA S2MM channel to start one receive transfer.
//  It is the writer on the DMA control bus whose LENGTH write (0x58) the receive-transfer tap observes.
//  On a start pulse it writes S2MM_DMACR (optional), S2MM_DA and S2MM_LENGTH, then reports done or error.

---
 rtl/axi_dma_regs_pkg.sv | 39 +++
 rtl/axi_lite_single_write.sv | 91 +++++++++
 rtl/axi_dma_receive_transfer_initiator.sv | 173 +++++++++++++++++
 tb/tb_axi_dma_receive_transfer_initiator.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_regs_pkg.sv
// ---------------------------------------------------------------------------
// axi_dma_regs_pkg
// Shared definitions for the AXI DMA S2MM control-register writer:
//   - S2MM register offsets in the DMA AXI-Lite register space
//   - DMACR run/stop value and the OKAY write response code
//   - write-sequence index encoding and the sequencer state type
//   - reg_addr(): maps a write-sequence index to its register offset
// ---------------------------------------------------------------------------
package axi_dma_regs_pkg;

    localparam logic [9:0]  S2MM_DMACR  = 10'h30;
    localparam logic [9:0]  S2MM_DA     = 10'h48;
    localparam logic [9:0]  S2MM_LENGTH = 10'h58;

    localparam logic [31:0] DMACR_RS    = 32'h1;
    localparam logic [1:0]  BRESP_OKAY  = 2'b00;

    // Position of each register in the write sequence. LENGTH is always
    // last because writing it launches the DMA transfer.
    localparam logic [1:0]  IDX_DMACR   = 2'd0;
    localparam logic [1:0]  IDX_DA      = 2'd1;
    localparam logic [1:0]  IDX_LENGTH  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP,
        ST_FINISH
    } state_e;

    function automatic logic [9:0] reg_addr(input logic [1:0] idx);
        case (idx)
            IDX_DMACR: reg_addr = S2MM_DMACR;
            IDX_DA:    reg_addr = S2MM_DA;
            default:   reg_addr = S2MM_LENGTH;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_single_write.sv
// ---------------------------------------------------------------------------
// axi_lite_single_write
// Performs one AXI-Lite write: AW and W are raised together on go, each drops
// the cycle after its own handshake, then B is accepted.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   go                  load addr/data and start a write (only when idle)
//   addr, data          register offset and write data, captured on go
//   sent                both AW and W complete in this cycle
//   ack                 write response accepted this cycle
//   resp                write response code (valid with ack)
//   m_axi_*             AXI-Lite write channels (AW, W, B)
// ---------------------------------------------------------------------------
module axi_lite_single_write #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      go,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     data,
    output logic                      sent,
    output logic                      ack,
    output logic [1:0]                resp,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_aw_hs;
    logic w_w_hs;

    assign w_aw_hs = r_awvalid && m_axi_awready;
    assign w_w_hs  = r_wvalid  && m_axi_wready;

    // The address phase ends when every channel still pending handshakes now;
    // a channel that already completed no longer holds it up.
    assign sent = (r_awvalid || r_wvalid)
               && (!r_awvalid || m_axi_awready)
               && (!r_wvalid  || m_axi_wready);

    assign ack  = r_bready && m_axi_bvalid;
    assign resp = m_axi_bresp;

    // NOTE: state updates use non-blocking (<=) so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
        end else if (go) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_bready  <= 1'b0;
            r_awaddr  <= addr;
            r_wdata   <= data;
        end else begin
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            if (sent)
                r_bready <= 1'b1;
            else if (ack)
                r_bready <= 1'b0;
        end
    end

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

endmodule

// File: rtl/axi_dma_receive_transfer_initiator.sv
// ---------------------------------------------------------------------------
// axi_dma_receive_transfer_initiator
// AXI-Lite master that programs the DMA S2MM channel for one receive transfer:
// optional DMACR run/stop, then DA, then LENGTH (which launches the DMA).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request pulse, honoured only while idle
//   dest_addr, length   transfer parameters, captured on an accepted start
//   busy                accepted start through the done/error cycle
//   done, error         one-cycle completion pulses
//   m_axi_*             AXI-Lite write master to the DMA s_axi_lite port
// ---------------------------------------------------------------------------
module axi_dma_receive_transfer_initiator
    import axi_dma_regs_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 26,
    parameter bit SET_RUN_STOP = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [31:0]             dest_addr,
    input  logic [LEN_WIDTH-1:0]    length,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam logic [1:0] FIRST_IDX = SET_RUN_STOP ? IDX_DMACR : IDX_DA;

    state_e                 r_state;
    state_e                 w_next_state;
    logic [1:0]             r_idx;
    logic [1:0]             w_next_idx;
    logic [31:0]            r_dest;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_err;
    logic                   r_zero_err;

    logic                   w_accept;
    logic                   w_zero_start;
    logic                   w_go;
    logic                   w_set_err;
    logic                   w_sent;
    logic                   w_ack;
    logic [1:0]             w_resp;
    logic [31:0]            w_src_dest;
    logic [LEN_WIDTH-1:0]   w_src_len;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [DATA_WIDTH-1:0]  w_wr_data;

    assign w_accept     = (r_state == ST_IDLE) && start && (length != '0);
    assign w_zero_start = (r_state == ST_IDLE) && start && (length == '0);

    // The first write is loaded on the same edge that captures the inputs,
    // so in IDLE the write data comes straight from the ports.
    assign w_src_dest = (r_state == ST_IDLE) ? dest_addr : r_dest;
    assign w_src_len  = (r_state == ST_IDLE) ? length    : r_len;

    assign w_wr_addr = ADDR_WIDTH'(reg_addr(w_next_idx));

    always_comb begin
        case (w_next_idx)
            IDX_DMACR: w_wr_data = DATA_WIDTH'(DMACR_RS);
            IDX_DA:    w_wr_data = DATA_WIDTH'(w_src_dest);
            default:   w_wr_data = DATA_WIDTH'(w_src_len);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_go         = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_ADDR;
                    w_next_idx   = FIRST_IDX;
                    w_go         = 1'b1;
                end
            end
            ST_ADDR: begin
                if (w_sent) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (w_ack) begin
                    if (w_resp != BRESP_OKAY) begin
                        w_set_err    = 1'b1;
                        w_next_state = ST_FINISH;
                    end else if (r_idx == IDX_LENGTH) begin
                        w_next_state = ST_FINISH;
                    end else begin
                        w_next_idx   = r_idx + 2'd1;
                        w_go         = 1'b1;
                        w_next_state = ST_ADDR;
                    end
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_dest     <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
            r_zero_err <= 1'b0;
        end else begin
            r_idx      <= w_next_idx;
            r_zero_err <= w_zero_start;
            if (w_accept) begin
                r_dest <= dest_addr;
                r_len  <= length;
                r_err  <= 1'b0;
            end else if (w_set_err) begin
                r_err  <= 1'b1;
            end
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_FINISH) && !r_err;
    // A zero-length request is rejected from IDLE without ever going busy.
    assign error = ((r_state == ST_FINISH) && r_err) || r_zero_err;

    axi_lite_single_write #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_write (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (w_go),
        .addr          (w_wr_addr),
        .data          (w_wr_data),
        .sent          (w_sent),
        .ack           (w_ack),
        .resp          (w_resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

endmodule

// File: tb/tb_axi_dma_receive_transfer_initiator.sv
// ---------------------------------------------------------------------------
// tb_axi_dma_receive_transfer_initiator
// Directed bench. Instance 0 has SET_RUN_STOP=1, instance 1 has
// SET_RUN_STOP=0. Each has an AXI-Lite slave model with programmable AW/W
// ready delays and an injectable error response; the model logs accepted
// addresses/data and counts protocol violations.
// ---------------------------------------------------------------------------
module tb_axi_dma_receive_transfer_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_s   [2];
    logic [31:0] dest_s    [2];
    logic [25:0] len_s     [2];
    logic        busy_s    [2];
    logic        done_s    [2];
    logic        error_s   [2];
    logic [9:0]  awaddr_s  [2];
    logic        awvalid_s [2];
    logic        awready_s [2];
    logic [31:0] wdata_s   [2];
    logic [3:0]  wstrb_s   [2];
    logic        wvalid_s  [2];
    logic        wready_s  [2];
    logic [1:0]  bresp_s   [2];
    logic        bvalid_s  [2];
    logic        bready_s  [2];

    axi_dma_receive_transfer_initiator #(.SET_RUN_STOP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .dest_addr(dest_s[0]),
        .length(len_s[0]), .busy(busy_s[0]), .done(done_s[0]), .error(error_s[0]),
        .m_axi_awaddr(awaddr_s[0]), .m_axi_awvalid(awvalid_s[0]),
        .m_axi_awready(awready_s[0]), .m_axi_wdata(wdata_s[0]),
        .m_axi_wstrb(wstrb_s[0]), .m_axi_wvalid(wvalid_s[0]),
        .m_axi_wready(wready_s[0]), .m_axi_bresp(bresp_s[0]),
        .m_axi_bvalid(bvalid_s[0]), .m_axi_bready(bready_s[0])
    );

    axi_dma_receive_transfer_initiator #(.SET_RUN_STOP(1'b0)) dut_no_rs (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .dest_addr(dest_s[1]),
        .length(len_s[1]), .busy(busy_s[1]), .done(done_s[1]), .error(error_s[1]),
        .m_axi_awaddr(awaddr_s[1]), .m_axi_awvalid(awvalid_s[1]),
        .m_axi_awready(awready_s[1]), .m_axi_wdata(wdata_s[1]),
        .m_axi_wstrb(wstrb_s[1]), .m_axi_wvalid(wvalid_s[1]),
        .m_axi_wready(wready_s[1]), .m_axi_bresp(bresp_s[1]),
        .m_axi_bvalid(bvalid_s[1]), .m_axi_bready(bready_s[1])
    );

    // ---------------- slave models (decide ready/valid on the falling edge)
    int          aw_delay [2];
    int          w_delay  [2];
    int          err_at   [2];
    int          aw_wait  [2];
    int          w_wait   [2];
    bit          aw_hs    [2];
    bit          w_hs     [2];
    bit          b_hs     [2];
    bit          aw_done  [2];
    bit          w_done   [2];
    logic [9:0]  aw_ref   [2];
    logic [31:0] w_ref    [2];
    int          aw_cnt   [2];
    int          w_cnt    [2];
    int          viol     [2];
    logic [9:0]  aw_log   [2][32];
    logic [31:0] w_log    [2][32];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                awready_s[i] = 1'b0; wready_s[i] = 1'b0;
                bvalid_s[i]  = 1'b0; bresp_s[i]  = 2'b00;
                aw_hs[i] = 1'b0; w_hs[i] = 1'b0; b_hs[i] = 1'b0;
                aw_done[i] = 1'b0; w_done[i] = 1'b0;
                aw_wait[i] = 0; w_wait[i] = 0;
            end else begin
                // effects of handshakes that completed on the last rising edge
                if (aw_hs[i]) aw_done[i] = 1'b1;
                if (w_hs[i])  w_done[i]  = 1'b1;
                if (b_hs[i]) begin
                    bvalid_s[i] = 1'b0; bresp_s[i] = 2'b00;
                    aw_done[i] = 1'b0; w_done[i] = 1'b0;
                end
                aw_hs[i] = 1'b0; w_hs[i] = 1'b0;
                // a valid still high after its handshake, or a new write before B
                if (aw_done[i] && awvalid_s[i]) viol[i]++;
                if (w_done[i]  && wvalid_s[i])  viol[i]++;

                if (awvalid_s[i] && !aw_done[i]) begin
                    if (aw_wait[i] == 0) aw_ref[i] = awaddr_s[i];
                    else if (awaddr_s[i] !== aw_ref[i]) viol[i]++;
                    if (aw_wait[i] >= aw_delay[i]) begin
                        awready_s[i] = 1'b1; aw_hs[i] = 1'b1;
                        if (aw_cnt[i] < 32) aw_log[i][aw_cnt[i]] = awaddr_s[i];
                        aw_cnt[i]++;
                    end else begin
                        awready_s[i] = 1'b0; aw_wait[i]++;
                    end
                end else begin
                    awready_s[i] = 1'b0; aw_wait[i] = 0;
                end

                if (wvalid_s[i] && !w_done[i]) begin
                    if (w_wait[i] == 0) w_ref[i] = wdata_s[i];
                    else if (wdata_s[i] !== w_ref[i]) viol[i]++;
                    if (w_wait[i] >= w_delay[i]) begin
                        wready_s[i] = 1'b1; w_hs[i] = 1'b1;
                        if (w_cnt[i] < 32) w_log[i][w_cnt[i]] = wdata_s[i];
                        w_cnt[i]++;
                    end else begin
                        wready_s[i] = 1'b0; w_wait[i]++;
                    end
                end else begin
                    wready_s[i] = 1'b0; w_wait[i] = 0;
                end

                if (aw_done[i] && w_done[i] && !bvalid_s[i]) begin
                    bvalid_s[i] = 1'b1;
                    bresp_s[i]  = (aw_cnt[i] - 1 == err_at[i]) ? 2'b10 : 2'b00;
                end
                b_hs[i] = bvalid_s[i] && bready_s[i];
            end
        end
    end

    // ---------------- checking
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // results of the last run_txn, in cycles after the start cycle (0)
    int done_k, err_k, busy_first, busy_last, done_n, err_n;

    task automatic run_txn(input int s, input logic [31:0] dest, input logic [25:0] len,
                           input int repulse_k, input logic [31:0] dest2, input int ncyc);
        @(negedge clk);
        start_s[s] = 1'b1; dest_s[s] = dest; len_s[s] = len;
        done_k = -1; err_k = -1; busy_first = -1; busy_last = -1; done_n = 0; err_n = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start_s[s] = (k == repulse_k);
            if (k == repulse_k) begin
                dest_s[s] = dest2; len_s[s] = 26'd64;
            end
            #1;
            if (done_s[s]) begin
                if (done_k < 0) done_k = k;
                done_n++;
            end
            if (error_s[s]) begin
                if (err_k < 0) err_k = k;
                err_n++;
            end
            if (busy_s[s]) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
        end
        start_s[s] = 1'b0;
    endtask

    int base_aw, base_w;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; dest_s[i] = '0; len_s[i] = '0;
            aw_delay[i] = 0; w_delay[i] = 0; err_at[i] = -1;
            aw_cnt[i] = 0; w_cnt[i] = 0; viol[i] = 0;
        end

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy_s[0]),    32'd0);
        check("rst_done",    32'(done_s[0]),    32'd0);
        check("rst_error",   32'(error_s[0]),   32'd0);
        check("rst_awvalid", 32'(awvalid_s[0]), 32'd0);
        check("rst_wvalid",  32'(wvalid_s[0]),  32'd0);
        check("rst_bready",  32'(bready_s[0]),  32'd0);
        check("rst_awaddr",  32'(awaddr_s[0]),  32'd0);
        check("rst_wdata",   wdata_s[0],        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: always-ready slave, full sequence
        base_aw = aw_cnt[0]; base_w = w_cnt[0];
        run_txn(0, 32'h1000_0000, 26'd512, -1, 32'h0, 12);
        check("t1_done_cycle", 32'(done_k),     32'd7);
        check("t1_done_count", 32'(done_n),     32'd1);
        check("t1_no_error",   32'(err_n),      32'd0);
        check("t1_busy_first", 32'(busy_first), 32'd1);
        check("t1_busy_last",  32'(busy_last),  32'd7);
        check("t1_aw_count",   32'(aw_cnt[0] - base_aw), 32'd3);
        check("t1_w_count",    32'(w_cnt[0] - base_w),   32'd3);
        check("t1_addr0", 32'(aw_log[0][base_aw]),     32'h30);
        check("t1_addr1", 32'(aw_log[0][base_aw + 1]), 32'h48);
        check("t1_addr2", 32'(aw_log[0][base_aw + 2]), 32'h58);
        check("t1_data0", w_log[0][base_w],     32'h1);
        check("t1_data1", w_log[0][base_w + 1], 32'h1000_0000);
        check("t1_data2", w_log[0][base_w + 2], 32'd512);
        check("t1_wstrb", 32'(wstrb_s[0]), 32'hF);

        // 2: awready 3 cycles late, wready immediate
        aw_delay[0] = 3;
        base_aw = aw_cnt[0]; base_w = w_cnt[0];
        run_txn(0, 32'h2222_0000, 26'h3FF_FFFF, -1, 32'h0, 24);
        aw_delay[0] = 0;
        check("t2_done_cycle", 32'(done_k), 32'd16);
        check("t2_no_error",   32'(err_n),  32'd0);
        check("t2_addr1", 32'(aw_log[0][base_aw + 1]), 32'h48);
        check("t2_data1", w_log[0][base_w + 1], 32'h2222_0000);
        check("t2_data2", w_log[0][base_w + 2], 32'h03FF_FFFF);
        check("t2_protocol_viol", 32'(viol[0]), 32'd0);

        // 3: SLVERR on the DA write
        base_aw = aw_cnt[0]; base_w = w_cnt[0];
        err_at[0] = base_aw + 1;
        run_txn(0, 32'h3333_0000, 26'd100, -1, 32'h0, 12);
        err_at[0] = -1;
        check("t3_err_cycle",  32'(err_k),   32'd5);
        check("t3_err_count",  32'(err_n),   32'd1);
        check("t3_no_done",    32'(done_n),  32'd0);
        check("t3_aw_count",   32'(aw_cnt[0] - base_aw), 32'd2);
        check("t3_busy_last",  32'(busy_last), 32'd5);

        // 4: zero length is rejected without bus traffic
        base_aw = aw_cnt[0];
        run_txn(0, 32'h4444_0000, 26'd0, -1, 32'h0, 6);
        check("t4_err_cycle",  32'(err_k),      32'd1);
        check("t4_err_count",  32'(err_n),      32'd1);
        check("t4_never_busy", 32'(busy_first), 32'hFFFF_FFFF);
        check("t4_no_aw",      32'(aw_cnt[0] - base_aw), 32'd0);
        check("t4_no_done",    32'(done_n),     32'd0);

        // 5: start re-pulsed mid-sequence with new dest/length is ignored
        base_aw = aw_cnt[0]; base_w = w_cnt[0];
        run_txn(0, 32'hA000_0000, 26'd100, 3, 32'hB000_0000, 14);
        check("t5_done_cycle", 32'(done_k),    32'd7);
        check("t5_done_count", 32'(done_n),    32'd1);
        check("t5_busy_last",  32'(busy_last), 32'd7);
        check("t5_aw_count",   32'(aw_cnt[0] - base_aw), 32'd3);
        check("t5_data1", w_log[0][base_w + 1], 32'hA000_0000);
        check("t5_data2", w_log[0][base_w + 2], 32'd100);

        // 6: reset while awvalid is high
        aw_delay[0] = 5;
        @(negedge clk);
        start_s[0] = 1'b1; dest_s[0] = 32'hC000_0000; len_s[0] = 26'd16;
        @(negedge clk);
        start_s[0] = 1'b0;
        #1;
        check("t6_awvalid_before", 32'(awvalid_s[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_awvalid", 32'(awvalid_s[0]), 32'd0);
        check("t6_rst_wvalid",  32'(wvalid_s[0]),  32'd0);
        check("t6_rst_busy",    32'(busy_s[0]),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        aw_delay[0] = 0;
        @(negedge clk);
        base_aw = aw_cnt[0]; base_w = w_cnt[0];
        run_txn(0, 32'h0000_2000, 26'd1024, -1, 32'h0, 12);
        check("t6_done_cycle", 32'(done_k), 32'd7);
        check("t6_aw_count",   32'(aw_cnt[0] - base_aw), 32'd3);
        check("t6_addr0", 32'(aw_log[0][base_aw]), 32'h30);
        check("t6_data1", w_log[0][base_w + 1], 32'h0000_2000);
        check("t6_data2", w_log[0][base_w + 2], 32'd1024);

        // SET_RUN_STOP=0: only DA and LENGTH are written
        base_aw = aw_cnt[1]; base_w = w_cnt[1];
        run_txn(1, 32'h3000_0000, 26'd2048, -1, 32'h0, 10);
        check("nors_done_cycle", 32'(done_k), 32'd5);
        check("nors_busy_last",  32'(busy_last), 32'd5);
        check("nors_aw_count",   32'(aw_cnt[1] - base_aw), 32'd2);
        check("nors_addr0", 32'(aw_log[1][base_aw]),     32'h48);
        check("nors_addr1", 32'(aw_log[1][base_aw + 1]), 32'h58);
        check("nors_data0", w_log[1][base_w],     32'h3000_0000);
        check("nors_data1", w_log[1][base_w + 1], 32'd2048);
        check("nors_wstrb", 32'(wstrb_s[1]), 32'hF);
        check("nors_protocol_viol", 32'(viol[1]), 32'd0);

        check("final_protocol_viol", 32'(viol[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
